mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers, run in parallel with the combinational ALU in EX.
- Executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO and holds HI/LO for MFHI/MFLO.
- Uses a start/busy/done handshake; the pipeline stalls on o_busy and flushes it via i_cancel.

---
 rtl/mdu_hilo_pkg.sv | 52 +++++
 rtl/mdu_hilo_if.sv | 24 ++
 rtl/mdu_div_core.sv | 57 +++++
 rtl/mdu_hilo.sv | 181 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared opcode, FSM encoding and decode helpers for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MADD  = 4'd4,
    MDU_MADDU = 4'd5,
    MDU_MSUB  = 4'd6,
    MDU_MSUBU = 4'd7,
    MDU_MTHI  = 4'd8,
    MDU_MTLO  = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  localparam logic [4:0] MDU_LAST_ITER = 5'd31;

  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_mul(input logic [MDU_OP_W-1:0] op);
    return !op[3] && !op_is_div(op);
  endfunction

  // Within the arithmetic codes 0..7 the even codes are the signed variants.
  function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
    return !op[3] && !op[0];
  endfunction

  function automatic logic op_is_acc(input logic [MDU_OP_W-1:0] op);
    return !op[3] && op[2];
  endfunction

  function automatic logic op_is_sub(input logic [MDU_OP_W-1:0] op);
    return !op[3] && op[2] && op[1];
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_hilo_if;
  import mdu_hilo_pkg::*;

  logic                i_start;
  logic [MDU_OP_W-1:0] i_op;
  logic [31:0]         i_opr1;
  logic [31:0]         i_opr2;
  logic                i_cancel;
  logic                o_busy;
  logic                o_done;
  logic [31:0]         o_hi;
  logic [31:0]         o_lo;

  modport master (
    output i_start, i_op, i_opr1, i_opr2, i_cancel,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_opr1, i_opr2, i_cancel,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/mdu_div_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per step, 32 steps per divide.
module mdu_div_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [32:0] shifted;
  logic [32:0] trial;

  // The dividend shifts out of the quotient register into the partial remainder.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dsr_q};
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
    end else if (step_i) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Define MDU_FAST_MUL_EN to replace the 32-step shift-add with one registered multiplier.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input logic        i_clk,
  input logic        i_rst,
  mdu_hilo_if.slave  bus
);

  mdu_state_e          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [MDU_OP_W-1:0] op_q;
  logic                neg_q, rneg_q, dz_q;
  logic [31:0]         raw1_q;
  logic [63:0]         prod_q;
  logic [31:0]         hi_q, lo_q;

  logic                mul_load, div_load, div_step, commit, mt_hi, mt_lo;
  logic                sgn_in;
  logic [31:0]         mag1, mag2;
  logic [31:0]         quotient, remainder;
  logic [63:0]         prod_fix, acc, commit_val;
  logic [31:0]         quo_fix, rem_fix;

`ifndef MDU_FAST_MUL_EN
  logic                mul_step;
  logic [31:0]         mcand_q;
  logic [32:0]         mul_sum;

  // Product register holds {partial sum, remaining multiplier bits}; it shifts right each step.
  assign mul_sum = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? mcand_q : 32'd0)};
`endif

  assign sgn_in = op_is_signed(bus.i_op);
  assign mag1   = mag32(bus.i_opr1, sgn_in);
  assign mag2   = mag32(bus.i_opr2, sgn_in);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    commit   = 1'b0;
    mt_hi    = 1'b0;
    mt_lo    = 1'b0;
`ifndef MDU_FAST_MUL_EN
    mul_step = 1'b0;
`endif
    unique case (state_q)
      MDU_IDLE: begin
        if (bus.i_start && !bus.i_cancel) begin
          cnt_d = '0;
          if (bus.i_op == MDU_MTHI) begin
            mt_hi = 1'b1;
          end else if (bus.i_op == MDU_MTLO) begin
            mt_lo = 1'b1;
          end else if (op_is_div(bus.i_op)) begin
            div_load = 1'b1;
            state_d  = (bus.i_opr2 == 32'd0) ? MDU_FIN : MDU_RUN;
          end else if (op_is_mul(bus.i_op)) begin
            mul_load = 1'b1;
`ifdef MDU_FAST_MUL_EN
            state_d  = MDU_FIN;
`else
            state_d  = MDU_RUN;
`endif
          end
        end
      end
      MDU_RUN: begin
        div_step = op_is_div(op_q);
`ifndef MDU_FAST_MUL_EN
        mul_step = !op_is_div(op_q);
`endif
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MDU_LAST_ITER) state_d = MDU_FIN;
      end
      MDU_FIN: begin
        commit  = 1'b1;
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    // A flush overrides everything, including a write due in FIN.
    if (bus.i_cancel) begin
      state_d  = MDU_IDLE;
      done_d   = 1'b0;
      commit   = 1'b0;
      div_step = 1'b0;
`ifndef MDU_FAST_MUL_EN
      mul_step = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    acc        = {hi_q, lo_q};
    prod_fix   = neg_q ? (~prod_q + 64'd1) : prod_q;
    quo_fix    = neg_q ? (~quotient + 32'd1) : quotient;
    rem_fix    = rneg_q ? (~remainder + 32'd1) : remainder;
    commit_val = prod_fix;
    if (dz_q)                   commit_val = {raw1_q, DIV_ZERO_LO};
    else if (op_is_div(op_q))   commit_val = {rem_fix, quo_fix};
    else if (op_is_acc(op_q))   commit_val = op_is_sub(op_q) ? (acc - prod_fix) : (acc + prod_fix);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: operand/accumulator registers are plain flops, so they reset with the FSM.
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      raw1_q  <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifndef MDU_FAST_MUL_EN
      mcand_q <= '0;
`endif
    end else begin
      if (mul_load || div_load) begin
        op_q   <= bus.i_op;
        neg_q  <= sgn_in & (bus.i_opr1[31] ^ bus.i_opr2[31]);
        rneg_q <= sgn_in & bus.i_opr1[31];
        dz_q   <= div_load && (bus.i_opr2 == 32'd0);
        raw1_q <= bus.i_opr1;
      end
`ifdef MDU_FAST_MUL_EN
      if (mul_load) prod_q <= {32'd0, mag1} * {32'd0, mag2};
`else
      if (mul_load) begin
        prod_q  <= {32'd0, mag2};
        mcand_q <= mag1;
      end else if (mul_step) begin
        prod_q  <= {mul_sum, prod_q[31:1]};
      end
`endif
      if (commit)     {hi_q, lo_q} <= commit_val;
      else if (mt_hi) hi_q <= bus.i_opr1;
      else if (mt_lo) lo_q <= bus.i_opr1;
    end
  end

  mdu_div_core u_div_core (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (mag1),
    .divisor_i   (mag2),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  assign bus.o_busy = (state_q != MDU_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI/LO pushed at issue, popped on o_done.
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] sb_q[$];
  logic [63:0] model_acc = '0;

  mdu_hilo_if bus();

  mdu_hilo #(.DIV_ZERO_LO(DZ_LO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc);
    logic [63:0] sa, sb, up, sp, res;
    logic signed [63:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    up = {32'd0, a} * {32'd0, b};
    sp = sa * sb;
    q  = '0;
    r  = '0;
    if (b != 32'd0) begin
      q = $signed(sa) / $signed(sb);
      r = $signed(sa) % $signed(sb);
    end
    case (op)
      4'd0:    res = sp;
      4'd1:    res = up;
      4'd2:    res = (b == 32'd0) ? {a, DZ_LO} : {r[31:0], q[31:0]};
      4'd3:    res = (b == 32'd0) ? {a, DZ_LO} : {a % b, a / b};
      4'd4:    res = acc + sp;
      4'd5:    res = acc + up;
      4'd6:    res = acc - sp;
      4'd7:    res = acc - up;
      4'd8:    res = {a, acc[31:0]};
      4'd9:    res = {acc[63:32], a};
      default: res = acc;
    endcase
    return res;
  endfunction

  task automatic drive_idle();
    bus.i_start  = 1'b0;
    bus.i_cancel = 1'b0;
    bus.i_op     = '0;
    bus.i_opr1   = '0;
    bus.i_opr2   = '0;
  endtask

  // Issue one op, optionally poke a start at cycle inject_cyc, then wait for o_done.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_cyc, input int inject_cyc);
    int   cyc;
    int   gaps;
    logic seen;
    logic [63:0] want;
    sb_q.push_back(exp);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_opr1  = a;
    bus.i_opr2  = b;
    cyc  = 0;
    gaps = 0;
    seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      bus.i_start = 1'b0;
      if (inject_cyc != 0 && cyc == inject_cyc) begin
        bus.i_start = 1'b1;
        bus.i_op    = MDU_MTHI;
        bus.i_opr1  = 32'hDEAD_BEEF;
      end
      if (bus.o_done) seen = 1'b1;
      else if (!bus.o_busy) gaps++;
    end
    want = sb_q.pop_front();
    if (!seen) begin
      check({tag, " timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, " cycle"}, 64'(cyc), 64'(exp_cyc));
      check({tag, " hilo"}, {bus.o_hi, bus.o_lo}, want);
      check({tag, " busy@done"}, 64'(bus.o_busy), 64'd0);
      check({tag, " busy gaps"}, 64'(gaps), 64'd0);
      @(negedge clk);
      check({tag, " done pulse"}, 64'(bus.o_done), 64'd0);
    end
    model_acc = want;
  endtask

  // Move-to (and ignored codes): visible after the accept edge, no busy, no done.
  task automatic do_move(input string tag, input logic [3:0] op, input logic [31:0] a);
    logic [63:0] want;
    want = model(op, a, 32'd0, model_acc);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_opr1  = a;
    @(negedge clk);
    bus.i_start = 1'b0;
    check({tag, " hilo"}, {bus.o_hi, bus.o_lo}, want);
    check({tag, " busy/done"}, {62'd0, bus.o_busy, bus.o_done}, 64'd0);
    model_acc = want;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen_done;
    seen_done = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.o_done) seen_done++;
    end
    check({tag, " no done"}, 64'(seen_done), 64'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          lat;
    drive_idle();
    repeat (3) @(negedge clk);
    check("reset hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    check("reset busy/done", {62'd0, bus.o_busy, bus.o_done}, 64'd0);
    rst = 1'b0;

    do_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, 0);
    do_op("mult neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT, 0);
    do_op("div neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
    do_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34, 0);
    do_op("divu zero", MDU_DIVU, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 2, 0);

    do_move("mthi", MDU_MTHI, 32'd1);
    do_move("mtlo", MDU_MTLO, 32'd2);
    do_op("maddu", MDU_MADDU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0003_0000_0000, MUL_LAT, 0);
    do_move("mtlo b", MDU_MTLO, 32'd10);
    do_move("mthi b", MDU_MTHI, 32'd0);
    do_op("msub", MDU_MSUB, 32'd3, 32'hFFFF_FFFE, 64'h0000_0000_0000_0010, MUL_LAT, 0);
    do_move("op12 ignored", 4'd12, 32'h5555_5555);

    // Start while busy must be dropped: the poked MTHI must not land.
    do_op("ignore start", MDU_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 34, 5);

    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = (i == 3) ? 32'd0 : $urandom();
      lat = op_is_div(rop) ? ((rb == 32'd0) ? 2 : 34) : MUL_LAT;
      do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb, model_acc), lat, 0);
    end

    // Cancel in cycle 10 of a divide.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = MDU_DIVU; bus.i_opr1 = 32'd999; bus.i_opr2 = 32'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.i_cancel = 1'b1;
    @(negedge clk);
    bus.i_cancel = 1'b0;
    check("cancel busy", 64'(bus.o_busy), 64'd0);
    check("cancel hilo", {bus.o_hi, bus.o_lo}, model_acc);
    watch_no_done("cancel", 40);

    // Cancel in the FIN cycle of a divide by zero.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = MDU_DIVU; bus.i_opr1 = 32'hABCD_0000; bus.i_opr2 = 32'd0;
    @(negedge clk);
    bus.i_start  = 1'b0;
    check("fin busy", 64'(bus.o_busy), 64'd1);
    bus.i_cancel = 1'b1;
    @(negedge clk);
    bus.i_cancel = 1'b0;
    check("fin cancel hilo", {bus.o_hi, bus.o_lo}, model_acc);
    check("fin cancel done", 64'(bus.o_done), 64'd0);

    // Cancel and start together: start dropped.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_cancel = 1'b1; bus.i_op = MDU_MTLO; bus.i_opr1 = 32'h7777_7777;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_cancel = 1'b0;
    check("cancel+start", {bus.o_hi, bus.o_lo}, model_acc);

    // Asynchronous reset in the middle of RUN.
    do_move("pre-rst mthi", MDU_MTHI, 32'hCAFE_F00D);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = MDU_DIV; bus.i_opr1 = 32'd50; bus.i_opr2 = 32'd5;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun rst hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    check("midrun rst busy", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_acc = '0;
    watch_no_done("post rst", 40);
    do_op("post rst multu", MDU_MULTU, 32'd6, 32'd7, 64'd42, MUL_LAT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
